scu_host_link: RTL and testbench
================================

SCU_HOST_LINK -- requirements
Module: scu_host_link

Interface
REQ-001 Parameter WDOG_CYCLES, default 5_000_000, means clk cycles without a valid frame before forced brake (100 ms at 50 MHz).
REQ-002 Parameter FRAME_BITS, default 32, means bits per SPI frame; only 32 is supported.
REQ-003 Port clk  input  1  system clock, 50 MHz; single clock domain for all internal logic.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port sclk  input  1  SPI clock from host MCU, asynchronous to clk, at most clk/8.
REQ-006 Port cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-007 Port mosi  input  1  SPI data from host, MSB first.
REQ-008 Port miso  output  1  SPI data to host, MSB first.
REQ-009 Port statusR  input  32  status word from the servo control unit, sampled once per frame.
REQ-010 Port inputR  output  32  command word to the servo control unit, registered.
REQ-011 Port inputValid  output  1  one-clk pulse when inputR is updated from a frame.
REQ-012 Port frameErr  output  1  one-clk pulse when a frame is discarded.
REQ-013 Port wdogTrip  output  1  level, high while the watchdog has forced brake.

Function
REQ-014 sclk, cs_n and mosi shall each pass through a 2-FF synchronizer; all edge detection shall use the synchronized signals.
REQ-015 SPI mode 0: mosi sampled on detected sclk rising edge; miso updated on detected sclk falling edge.
REQ-016 FSM states IDLE, SHIFT, CHECK; reset state IDLE.
REQ-017 IDLE -> SHIFT on cs_n falling edge: load tx register with statusR, clear bit counter to 0, drive miso = statusR[31] in the same cycle.
REQ-018 In SHIFT, each sclk rising edge shall shift mosi into rx register LSB and increment the 6-bit counter; each falling edge shall shift tx left and present the next bit on miso.
REQ-019 Counter shall saturate at 33; a count above 32 marks overrun.
REQ-020 SHIFT -> CHECK on cs_n rising edge; CHECK -> IDLE unconditionally after one cycle.
REQ-021 In CHECK with count == 32: inputR <= rx, inputValid = 1, watchdog counter cleared.
REQ-022 In CHECK with count != 32 (short or overrun): inputR unchanged, frameErr = 1.
REQ-023 Simultaneous sclk edge and cs_n rising edge shall process the sclk edge first, counting the bit.
REQ-024 miso shall be 0 whenever the state is not SHIFT.
REQ-025 The watchdog counter shall increment every clk and saturate at WDOG_CYCLES.
REQ-026 On reaching WDOG_CYCLES: inputR[30:29] <= 2'b10 (brake), other bits held, wdogTrip = 1.
REQ-027 wdogTrip clears on the next valid frame (REQ-021).
REQ-028 A valid frame and a watchdog expiry in the same cycle: the frame wins.
REQ-029 Latency from cs_n pin rising to the inputValid pulse: 4 clk cycles (2 sync, 1 edge detect, 1 CHECK).

Reset
REQ-030 reset shall force: state IDLE; counters 0; rx/tx 0; miso 0; inputValid 0; frameErr 0; wdogTrip 0; inputR = 32'h4000_0000 (brake command, angle 0).
REQ-031 reset asserted mid-frame shall abort the frame without a frameErr pulse; after reset deasserts, a new cs_n falling edge is required to start a frame.

Structure
REQ-032 Shared package scu_pkg shall hold: CMD_RUN/CMD_RESET/CMD_BRAKE encodings, inputR field LSB/MSB constants (angle 11:0, period 19:12, mode 28:27, cmd 30:29, power 31), BRAKE_WORD = 32'h4000_0000, and the link FSM state enum.
REQ-033 The synchronizer shall be one sub-module, sync2 (1-bit, reset to a parameterised value; cs_n resets to 1), instantiated three times.

Verification
REQ-034 Valid frame 0x0123_4ABC with statusR = 0x0000_03E8 -> inputR = 0x0123_4ABC, one inputValid pulse, miso stream = 0x0000_03E8.
REQ-035 Frame of 31 bits -> frameErr pulse, inputR keeps its prior value, no inputValid.
REQ-036 Frame of 34 bits -> frameErr pulse, inputR unchanged.
REQ-037 WDOG_CYCLES = 100, no frames after the value 0x2000_0100 is loaded -> at cycle 100 inputR = 0x4000_0100 and wdogTrip = 1; a next valid frame 0x0000_0200 clears wdogTrip.
REQ-038 reset asserted after 16 bits of a frame -> outputs at reset values, no frameErr; the next full frame is accepted normally.
REQ-039 Back-to-back frames with 2 clk cs_n-high gap at sclk = clk/8 -> both accepted, two inputValid pulses.

Source files
------------

// File: rtl/scu_pkg.sv
// Shared definitions for the servo control unit host link: command encodings,
// inputR field positions and the link FSM state type.
package scu_pkg;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b11;
  localparam logic [1:0] CMD_BRAKE = 2'b10;

  localparam int ANGLE_LSB  = 0;
  localparam int ANGLE_MSB  = 11;
  localparam int PERIOD_LSB = 12;
  localparam int PERIOD_MSB = 19;
  localparam int MODE_LSB   = 27;
  localparam int MODE_MSB   = 28;
  localparam int CMD_LSB    = 29;
  localparam int CMD_MSB    = 30;
  localparam int POWER_BIT  = 31;

  localparam logic [31:0] BRAKE_WORD  = 32'h4000_0000;
  localparam logic [5:0]  BIT_CNT_MAX = 6'd33;

  typedef enum logic [1:0] {
    LINK_IDLE,
    LINK_SHIFT,
    LINK_CHECK
  } link_state_e;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/scu_host_link.sv
// SPI (mode 0) slave carrying 32-bit command/status frames between the host MCU
// and the servo control unit, with a watchdog that forces brake on link loss.
module scu_host_link
  import scu_pkg::*;
#(
  parameter int WDOG_CYCLES = 5_000_000,
  parameter int FRAME_BITS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [31:0] statusR,
  output logic [31:0] inputR,
  output logic        inputValid,
  output logic        frameErr,
  output logic        wdogTrip
);
  localparam int         WD_W      = $clog2(WDOG_CYCLES + 1);
  localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_SAT  = WD_W'(WDOG_CYCLES);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_p_q, cs_p_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d_i(sclk), .q_o(sclk_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d_i(cs_n), .q_o(cs_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d_i(mosi), .q_o(mosi_s));

  assign sclk_rise = sclk_s & ~sclk_p_q;
  assign sclk_fall = ~sclk_s & sclk_p_q;
  assign cs_rise   = cs_s & ~cs_p_q;
  assign cs_fall   = ~cs_s & cs_p_q;

  link_state_e     state_q, state_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [31:0]     rx_q, rx_d, tx_q, tx_d, input_q, input_d;
  logic            miso_q, miso_d, valid_q, valid_d, err_q, err_d, trip_q, trip_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    input_d   = input_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    trip_d    = trip_q;
    wd_cnt_d  = (wd_cnt_q >= WD_LAST) ? WD_SAT : wd_cnt_q + 1'b1;
    // Expiry keeps re-asserting brake while saturated; only the cmd field changes.
    if (wd_cnt_q >= WD_LAST) begin
      input_d[CMD_MSB:CMD_LSB] = CMD_BRAKE;
      trip_d                   = 1'b1;
    end
    case (state_q)
      LINK_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = LINK_SHIFT;
          tx_d      = statusR;
          bit_cnt_d = '0;
          miso_d    = statusR[31];
        end
      end
      LINK_SHIFT: begin
        // sclk edges are handled before cs_rise so a coincident last bit still counts.
        if (sclk_rise) begin
          rx_d      = {rx_q[30:0], mosi_s};
          bit_cnt_d = (bit_cnt_q == BIT_CNT_MAX) ? BIT_CNT_MAX : bit_cnt_q + 1'b1;
        end
        if (sclk_fall) begin
          tx_d   = {tx_q[30:0], 1'b0};
          miso_d = tx_q[30];
        end
        if (cs_rise) begin
          state_d = LINK_CHECK;
          miso_d  = 1'b0;
        end
      end
      LINK_CHECK: begin
        state_d = LINK_IDLE;
        if (bit_cnt_q == FRAME_CNT) begin
          input_d  = rx_q;
          valid_d  = 1'b1;
          wd_cnt_d = '0;
          trip_d   = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = LINK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_p_q  <= 1'b0;
      cs_p_q    <= 1'b1;
      state_q   <= LINK_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      input_q   <= BRAKE_WORD;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      trip_q    <= 1'b0;
      wd_cnt_q  <= '0;
    end else begin
      sclk_p_q  <= sclk_s;
      cs_p_q    <= cs_s;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      input_q   <= input_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      trip_q    <= trip_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign miso       = miso_q & (state_q == LINK_SHIFT);
  assign inputR     = input_q;
  assign inputValid = valid_q;
  assign frameErr   = err_q;
  assign wdogTrip   = trip_q;
endmodule

// File: tb/tb_scu_host_link.sv
// Directed plus randomized SPI frames against a frame-level model of the host link.
module tb_scu_host_link;
  import scu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, sclk, cs_n, mosi;
  logic [31:0] statusR;
  logic        miso, inputValid, frameErr, wdogTrip;
  logic [31:0] inputR;
  logic        wd_miso, wd_valid, wd_err, wd_trip;
  logic [31:0] wd_inputR;

  always #5 clk = ~clk;

  scu_host_link u_dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .statusR(statusR), .inputR(inputR), .inputValid(inputValid),
    .frameErr(frameErr), .wdogTrip(wdogTrip)
  );

  scu_host_link #(.WDOG_CYCLES(100)) u_wd (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(wd_miso),
    .statusR(statusR), .inputR(wd_inputR), .inputValid(wd_valid),
    .frameErr(wd_err), .wdogTrip(wd_trip)
  );

  int ncmp = 0, nfail = 0;
  int nval = 0, nerr = 0;
  logic [31:0] exp_r;
  int nb[8] = '{32, 32, 32, 31, 33, 34, 1, 40};

  always @(posedge clk) begin
    if (inputValid) nval <= nval + 1;
    if (frameErr)   nerr <= nerr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [63:0] w, input int n, output logic [63:0] cap);
    cap = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = w[i];
      clks(4);
      cap  = {cap[62:0], miso};
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [63:0] w, input int n, input logic [31:0] st, input string tag);
    logic [63:0] cap, sh;
    int v0, e0;
    statusR = st;
    v0 = nval;
    e0 = nerr;
    chk({tag, ".idle_miso"}, 32'(miso), 32'd0);
    cs_n = 1'b0;
    clks(8);
    send_bits(w, n, cap);
    clks(4);
    cs_n = 1'b1;
    clks(8);
    if (n == 32) exp_r = w[31:0];
    chk({tag, ".inputR"}, inputR, exp_r);
    chk({tag, ".valid_pulses"}, 32'(nval - v0), (n == 32) ? 32'd1 : 32'd0);
    chk({tag, ".err_pulses"}, 32'(nerr - e0), (n == 32) ? 32'd0 : 32'd1);
    if (n >= 32) begin
      sh = cap >> (n - 32);
      chk({tag, ".miso_stream"}, sh[31:0], st);
    end
    chk({tag, ".miso_after"}, 32'(miso), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] w, cap;
    logic [31:0] st;
    int v0, e0, lat;

    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; statusR = '0;
    clks(3);
    chk("rst.inputR", inputR, BRAKE_WORD);
    chk("rst.valid", 32'(inputValid), 32'd0);
    chk("rst.err", 32'(frameErr), 32'd0);
    chk("rst.trip", 32'(wdogTrip), 32'd0);
    chk("rst.miso", 32'(miso), 32'd0);
    reset = 1'b0;
    exp_r = BRAKE_WORD;
    clks(2);

    frame(64'h0123_4ABC, 32, 32'h0000_03E8, "nominal");
    frame(64'(32'h5555_AAAA), 31, 32'h1234_5678, "short31");
    frame(64'h3_FFFF_0000, 34, 32'h8000_0001, "over34");
    frame(64'h0, 0, 32'hFFFF_FFFF, "empty");

    // Last sclk rise and cs_n rise arrive together: the bit must still count.
    w = 64'(32'h9ABC_DEF1);
    statusR = 32'hCAFE_0001;
    v0 = nval;
    cs_n = 1'b0;
    clks(8);
    send_bits(w >> 1, 31, cap);
    mosi = w[0];
    clks(4);
    sclk = 1'b1;
    cs_n = 1'b1;
    clks(8);
    sclk = 1'b0;
    clks(2);
    exp_r = w[31:0];
    chk("coincident.inputR", inputR, exp_r);
    chk("coincident.valid_pulses", 32'(nval - v0), 32'd1);

    // Watchdog: load 0x2000_0100, measure pin-to-pulse latency, then idle 100 cycles.
    statusR = 32'h0;
    cs_n = 1'b0;
    clks(8);
    send_bits(64'h2000_0100, 32, cap);
    clks(4);
    cs_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (wd_valid) begin
        lat = k;
        break;
      end
    end
    chk("wdog.latency", 32'(lat), 32'd4);
    exp_r = 32'h2000_0100;
    chk("wdog.main_inputR", inputR, exp_r);
    clks(99);
    chk("wdog.pre_inputR", wd_inputR, 32'h2000_0100);
    chk("wdog.pre_trip", 32'(wd_trip), 32'd0);
    clks(1);
    chk("wdog.brake_inputR", wd_inputR, 32'h4000_0100);
    chk("wdog.trip", 32'(wd_trip), 32'd1);
    chk("wdog.main_no_trip", 32'(wdogTrip), 32'd0);
    frame(64'h0000_0200, 32, 32'h0BAD_F00D, "wdog_clear");
    chk("wdog.clear_trip", 32'(wd_trip), 32'd0);
    chk("wdog.clear_inputR", wd_inputR, 32'h0000_0200);

    // Reset after 16 bits: abort silently, then a full frame is accepted.
    statusR = 32'h7777_1111;
    v0 = nval;
    e0 = nerr;
    cs_n = 1'b0;
    clks(8);
    send_bits(64'hBEEF, 16, cap);
    reset = 1'b1;
    cs_n = 1'b1;
    clks(3);
    chk("midrst.inputR", inputR, BRAKE_WORD);
    chk("midrst.miso", 32'(miso), 32'd0);
    chk("midrst.trip", 32'(wd_trip), 32'd0);
    reset = 1'b0;
    exp_r = BRAKE_WORD;
    clks(10);
    chk("midrst.no_err", 32'(nerr - e0), 32'd0);
    chk("midrst.no_valid", 32'(nval - v0), 32'd0);
    frame(64'h1357_9BDF, 32, 32'h2468_ACE0, "after_rst");

    // Back-to-back frames with a 2-clk cs_n-high gap.
    v0 = nval;
    e0 = nerr;
    statusR = 32'h0F0F_0F0F;
    cs_n = 1'b0;
    clks(8);
    send_bits(64'hAAAA_0001, 32, cap);
    clks(4);
    cs_n = 1'b1;
    clks(2);
    cs_n = 1'b0;
    clks(8);
    send_bits(64'h5555_0002, 32, cap);
    clks(4);
    cs_n = 1'b1;
    clks(8);
    exp_r = 32'h5555_0002;
    chk("b2b.valid_pulses", 32'(nval - v0), 32'd2);
    chk("b2b.err_pulses", 32'(nerr - e0), 32'd0);
    chk("b2b.inputR", inputR, exp_r);

    for (int it = 0; it < 10; it++) begin
      w  = {$urandom(), $urandom()};
      st = $urandom();
      frame(w, nb[$urandom_range(0, 7)], st, $sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
